// File: rtl/sub32_if.sv
// Operand/result handshake bundle for the sequential 32-bit subtractor.
interface sub32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        overflow;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, overflow
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow, zero, overflow
  );
endinterface

// File: rtl/sub32_seq.sv
// Multi-cycle 32-bit subtractor: diff = a - b - bin, computed as a + ~b + ~bin
// one SLICE_W-bit slice per cycle, each slice built from 4-bit lookahead groups.
module sub32_seq #(
  parameter int SLICE_W = 8
) (
  input  logic   clk,
  input  logic   rst,
  sub32_if.slave s
);
  localparam int NUM_SLICES = 32 / SLICE_W;
  localparam int NG         = SLICE_W / 4;
  localparam int KW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [31:0]     a_r, nb_r, diff_r;
  logic            cy;
  logic [KW-1:0]   k;
  logic            borrow_r, zero_r, ovf_r, ovalid_r;

  logic [SLICE_W-1:0] sa, sb, ssum;
  logic               cout;
  logic [31:0]        nd;

  // 4-bit carry-lookahead group: returns {carry_out, sum}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Current slice of a + ~b + carry; groups ripple their carries inside the slice,
  // the slice carry crosses into the next cycle through cy.
  always_comb begin
    logic       c;
    logic [4:0] r;
    sa   = a_r[k*SLICE_W +: SLICE_W];
    sb   = nb_r[k*SLICE_W +: SLICE_W];
    ssum = '0;
    c    = cy;
    for (int g = 0; g < NG; g++) begin
      r              = cla4(sa[g*4 +: 4], sb[g*4 +: 4], c);
      ssum[g*4 +: 4] = r[3:0];
      c              = r[4];
    end
    cout = c;
  end

  // Full result as it will look once this slice is written; used for zero/overflow
  always_comb begin
    nd                       = diff_r;
    nd[k*SLICE_W +: SLICE_W] = ssum;
  end

  // Control FSM with registered result/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      nb_r     <= '0;
      cy       <= 1'b0;
      k        <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      ovalid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s.in_valid) begin
          a_r   <= s.a;
          nb_r  <= ~s.b;
          cy    <= ~s.bin;
          k     <= '0;
          state <= CALC;
        end
        CALC: begin
          diff_r <= nd;
          cy     <= cout;
          if (k == KW'(NUM_SLICES - 1)) begin
            // carry out of a + ~b + ~bin is the inverse of the borrow
            borrow_r <= ~cout;
            zero_r   <= (nd == 32'd0);
            ovf_r    <= (a_r[31] ^ ~nb_r[31]) & (nd[31] ^ a_r[31]);
            ovalid_r <= 1'b1;
            state    <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: if (s.out_ready) begin
          ovalid_r <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s.in_ready  = (state == IDLE) & ~rst;
  assign s.out_valid = ovalid_r;
  assign s.diff      = diff_r;
  assign s.borrow    = borrow_r;
  assign s.zero      = zero_r;
  assign s.overflow  = ovf_r;
endmodule

// File: tb/tb_sub32_seq.sv
// Directed bench for sub32_seq at SLICE_W = 8 (main), 4 and 16.
module tb_sub32_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sub32_if i8 ();
  sub32_if i4 ();
  sub32_if i16 ();

  sub32_seq #(.SLICE_W(8))  dut8  (.clk(clk), .rst(rst), .s(i8.slave));
  sub32_seq #(.SLICE_W(4))  dut4  (.clk(clk), .rst(rst), .s(i4.slave));
  sub32_seq #(.SLICE_W(16)) dut16 (.clk(clk), .rst(rst), .s(i16.slave));

  // Drive one operation on the 8-bit-slice unit and return its result; latency
  // counts clock edges from the accept edge to out_valid (99 if it never rises).
  task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic bin,
                     output logic [31:0] d, output logic bo, output logic z,
                     output logic ov, output int lat);
    @(negedge clk);
    i8.a = a; i8.b = b; i8.bin = bin; i8.in_valid = 1'b1;
    @(posedge clk);
    #1 i8.in_valid = 1'b0; i8.a = $urandom; i8.b = $urandom; i8.bin = 1'b1;
    lat = 99;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (i8.out_valid) begin lat = c; break; end
    end
    d = i8.diff; bo = i8.borrow; z = i8.zero; ov = i8.overflow;
    i8.out_ready = 1'b1;
    @(posedge clk); #1 i8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (i8.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", i8.in_ready); end
    rst = 1'b0; #1;
    checks++; if (i8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", i8.out_valid); end
    checks++; if (i8.diff !== 32'd0) begin errors++; $display("FAIL rst_diff: got %h want 0", i8.diff); end
    checks++; if ({i8.borrow, i8.zero, i8.overflow} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {i8.borrow, i8.zero, i8.overflow}); end
    checks++; if (i8.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", i8.in_ready); end
    checks++; if ({i4.in_ready, i16.in_ready} !== 2'b11) begin errors++; $display("FAIL idle_in_ready_w: got %b want 11", {i4.in_ready, i16.in_ready}); end
  endtask

  // Arithmetic vectors: {a, b, bin, diff, borrow, zero, overflow}
  task automatic test_arith;
    logic [31:0] va[7], vb[7], vd[7];
    logic        vbin[7], vbo[7], vz[7], vov[7];
    logic [31:0] d;
    logic        bo, z, ov;
    int          lat;
    va[0]=32'd5;        vb[0]=32'd3;        vbin[0]=0; vd[0]=32'h00000002; vbo[0]=0; vz[0]=0; vov[0]=0;
    va[1]=32'd0;        vb[1]=32'd1;        vbin[1]=0; vd[1]=32'hFFFFFFFF; vbo[1]=1; vz[1]=0; vov[1]=0;
    va[2]=32'h00010000; vb[2]=32'd1;        vbin[2]=0; vd[2]=32'h0000FFFF; vbo[2]=0; vz[2]=0; vov[2]=0;
    va[3]=32'h80000000; vb[3]=32'd1;        vbin[3]=0; vd[3]=32'h7FFFFFFF; vbo[3]=0; vz[3]=0; vov[3]=1;
    va[4]=32'h7FFFFFFF; vb[4]=32'hFFFFFFFF; vbin[4]=0; vd[4]=32'h80000000; vbo[4]=1; vz[4]=0; vov[4]=1;
    va[5]=32'h00001234; vb[5]=32'h00001234; vbin[5]=0; vd[5]=32'h00000000; vbo[5]=0; vz[5]=1; vov[5]=0;
    va[6]=32'h00001234; vb[6]=32'h00001234; vbin[6]=1; vd[6]=32'hFFFFFFFF; vbo[6]=1; vz[6]=0; vov[6]=0;
    for (int i = 0; i < 7; i++) begin
      op8(va[i], vb[i], vbin[i], d, bo, z, ov, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL v%0d_latency: got %0d want 4", i, lat); end
      checks++; if (d !== vd[i]) begin errors++; $display("FAIL v%0d_diff: got %h want %h", i, d, vd[i]); end
      checks++; if (bo !== vbo[i]) begin errors++; $display("FAIL v%0d_borrow: got %b want %b", i, bo, vbo[i]); end
      checks++; if (z !== vz[i]) begin errors++; $display("FAIL v%0d_zero: got %b want %b", i, z, vz[i]); end
      checks++; if (ov !== vov[i]) begin errors++; $display("FAIL v%0d_overflow: got %b want %b", i, ov, vov[i]); end
      checks++; if ({i8.out_valid, i8.in_ready} !== 2'b01) begin errors++; $display("FAIL v%0d_release: got ov/ir %b want 01", i, {i8.out_valid, i8.in_ready}); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    logic        bo, z, ov;
    int          lat;
    @(negedge clk);
    i8.a = 32'd20; i8.b = 32'd5; i8.bin = 1'b0; i8.in_valid = 1'b1;
    @(posedge clk); #1 i8.in_valid = 1'b0;
    lat = 99;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (i8.out_valid) begin lat = c; break; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i8.in_valid = 1'b1; i8.a = 32'd99 + i; i8.b = 32'd1; i8.bin = 1'b0;
      @(posedge clk); #1;
      checks++; if ({i8.out_valid, i8.in_ready} !== 2'b10) begin errors++; $display("FAIL bp_hold_hs%0d: got ov/ir %b want 10", i, {i8.out_valid, i8.in_ready}); end
      checks++; if ({i8.diff, i8.borrow, i8.zero, i8.overflow} !== {32'd15, 3'b000}) begin errors++; $display("FAIL bp_hold_out%0d: got %h/%b%b%b want 0000000f/000", i, i8.diff, i8.borrow, i8.zero, i8.overflow); end
    end
    @(negedge clk);
    i8.in_valid = 1'b0; i8.out_ready = 1'b1;
    @(posedge clk); #1 i8.out_ready = 1'b0;
    checks++; if ({i8.out_valid, i8.in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got ov/ir %b want 01", {i8.out_valid, i8.in_ready}); end
    op8(32'd7, 32'd2, 1'b0, d, bo, z, ov, lat);
    checks++; if ({d, bo} !== {32'd5, 1'b0} || lat !== 4) begin errors++; $display("FAIL bp_next_op: got %h/%b lat %0d want 00000005/0 lat 4", d, bo, lat); end
  endtask

  task automatic test_reset_calc;
    logic [31:0] d;
    logic        bo, z, ov;
    int          lat;
    @(negedge clk);
    i8.a = 32'hFFFF0000; i8.b = 32'h00000001; i8.bin = 1'b0; i8.in_valid = 1'b1;
    @(posedge clk); #1 i8.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; #1;
    checks++; if (i8.out_valid !== 1'b0) begin errors++; $display("FAIL rc_out_valid: got %b want 0", i8.out_valid); end
    checks++; if (i8.diff !== 32'd0) begin errors++; $display("FAIL rc_diff: got %h want 0", i8.diff); end
    checks++; if (i8.in_ready !== 1'b1) begin errors++; $display("FAIL rc_in_ready: got %b want 1", i8.in_ready); end
    op8(32'd100, 32'd58, 1'b0, d, bo, z, ov, lat);
    checks++; if (d !== 32'd42) begin errors++; $display("FAIL rc_diff42: got %h want 0000002a", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rc_latency: got %0d want 4", lat); end
  endtask

  // SLICE_W = 4 and 16 units driven side by side
  task automatic test_widths;
    logic [31:0] va[3], vb[3], vd[3];
    logic        vbo[3], vov[3];
    int          l4, l16;
    @(negedge clk);
    i4.a = 32'h12345678; i4.b = 32'h1; i4.bin = 1'b0; i4.in_valid = 1'b1;
    i16.a = 32'h12345678; i16.b = 32'h1; i16.bin = 1'b0; i16.in_valid = 1'b1;
    @(posedge clk); #1 i4.in_valid = 1'b0; i16.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; #1;
    checks++; if ({i4.out_valid, i4.in_ready} !== 2'b01 || i4.diff !== 32'd0) begin errors++; $display("FAIL w4_reset: got ov/ir %b diff %h want 01 0", {i4.out_valid, i4.in_ready}, i4.diff); end
    checks++; if ({i16.out_valid, i16.in_ready} !== 2'b01 || i16.diff !== 32'd0) begin errors++; $display("FAIL w16_reset: got ov/ir %b diff %h want 01 0", {i16.out_valid, i16.in_ready}, i16.diff); end
    va[0]=32'd100;        vb[0]=32'd58;         vd[0]=32'd42;         vbo[0]=0; vov[0]=0;
    va[1]=32'h00010000;   vb[1]=32'd1;          vd[1]=32'h0000FFFF;   vbo[1]=0; vov[1]=0;
    va[2]=32'h7FFFFFFF;   vb[2]=32'hFFFFFFFF;   vd[2]=32'h80000000;   vbo[2]=1; vov[2]=1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i4.a = va[i]; i4.b = vb[i]; i4.bin = 1'b0; i4.in_valid = 1'b1;
      i16.a = va[i]; i16.b = vb[i]; i16.bin = 1'b0; i16.in_valid = 1'b1;
      @(posedge clk); #1 i4.in_valid = 1'b0; i16.in_valid = 1'b0;
      l4 = 99; l16 = 99;
      for (int c = 1; c <= 30; c++) begin
        @(posedge clk); #1;
        if (i4.out_valid && l4 == 99) l4 = c;
        if (i16.out_valid && l16 == 99) l16 = c;
        if (l4 != 99 && l16 != 99) break;
      end
      checks++; if (l4 !== 8) begin errors++; $display("FAIL w4_v%0d_latency: got %0d want 8", i, l4); end
      checks++; if (l16 !== 2) begin errors++; $display("FAIL w16_v%0d_latency: got %0d want 2", i, l16); end
      checks++; if ({i4.diff, i4.borrow, i4.overflow} !== {vd[i], vbo[i], vov[i]}) begin errors++; $display("FAIL w4_v%0d_result: got %h/%b%b want %h/%b%b", i, i4.diff, i4.borrow, i4.overflow, vd[i], vbo[i], vov[i]); end
      checks++; if ({i16.diff, i16.borrow, i16.overflow} !== {vd[i], vbo[i], vov[i]}) begin errors++; $display("FAIL w16_v%0d_result: got %h/%b%b want %h/%b%b", i, i16.diff, i16.borrow, i16.overflow, vd[i], vbo[i], vov[i]); end
      @(negedge clk) begin i4.out_ready = 1'b1; i16.out_ready = 1'b1; end
      @(posedge clk); #1 i4.out_ready = 1'b0; i16.out_ready = 1'b0;
    end
  endtask

  initial begin
    i8.in_valid = 1'b0;  i8.a = '0;  i8.b = '0;  i8.bin = 1'b0;  i8.out_ready = 1'b0;
    i4.in_valid = 1'b0;  i4.a = '0;  i4.b = '0;  i4.bin = 1'b0;  i4.out_ready = 1'b0;
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.bin = 1'b0; i16.out_ready = 1'b0;
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_calc;
    test_widths;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
